// File: rtl/gfifo_req_sched.sv
// Round-robin scheduler sharing one GFIFO host channel between NUM_REQ requesters.
// Responses carry no ID, so issue order is recorded and used to route each return beat.
module gfifo_req_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 512,
    parameter int ID_W    = 22,
    parameter int LEN_W   = 4,
    parameter int MAX_LEN = 8,
    parameter int OUTST   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [DATA_W-1:0]           gf_i_data,
    output logic [ID_W-1:0]             gf_t_id,
    output logic                        gf_i_valid,
    input  logic                        gf_i_ready,
    input  logic [DATA_W-1:0]           gf_o_data,
    input  logic                        gf_o_en,
    input  logic [LEN_W-1:0]            gf_o_len,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic [DATA_W-1:0]           resp_data,
    output logic [LEN_W-1:0]            resp_len,
    output logic [$clog2(OUTST):0]      outst_cnt,
    output logic                        err_unexp,
    output logic                        err_len
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SEQ_W = ID_W - IDX_W;
    localparam int PTR_W = $clog2(OUTST);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0]  req_slice [NUM_REQ];

    logic [IDX_W-1:0]   rr_q;
    logic [SEQ_W-1:0]   seq_q [NUM_REQ];
    logic [IDX_W-1:0]   fifo_q [OUTST];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               gi_valid_q, gi_valid_d;
    logic [DATA_W-1:0]  gi_data_q, gi_data_d;
    logic [ID_W-1:0]    gi_id_q, gi_id_d;

    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]  resp_data_q, resp_data_d;
    logic [LEN_W-1:0]   resp_len_q, resp_len_d;
    logic               err_unexp_q, err_unexp_d;
    logic               err_len_q, err_len_d;

    logic               found;
    logic [IDX_W-1:0]   win, idx;
    logic               slot_free, grant_ok, accept, pop;
    logic [IDX_W-1:0]   head;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_slice[g] = req_data[g*DATA_W +: DATA_W];
    end

    // First valid requester at or after the RR pointer, wrapping upward.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = rr_q + IDX_W'(k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Grant uses the pre-pop count, so a full tracker never bypasses.
    assign slot_free = !gi_valid_q || gf_i_ready;
    assign grant_ok  = slot_free && (cnt_q < CNT_W'(OUTST));
    assign accept    = grant_ok && found;
    assign pop       = gf_o_en && (cnt_q != '0);
    assign head      = fifo_q[rd_ptr_q];

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        gi_valid_d   = gi_valid_q;
        gi_data_d    = gi_data_q;
        gi_id_d      = gi_id_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        resp_len_d   = resp_len_q;
        if (accept) begin
            gi_valid_d = 1'b1;
            gi_data_d  = req_slice[win];
            gi_id_d    = {win, seq_q[win]};
        end else if (gf_i_ready) begin
            gi_valid_d = 1'b0;
        end
        if (pop) begin
            resp_valid_d[head] = 1'b1;
            resp_data_d        = gf_o_data;
            resp_len_d         = gf_o_len;
        end
        cnt_d       = cnt_q + CNT_W'(accept) - CNT_W'(pop);
        err_unexp_d = err_unexp_q | (gf_o_en && (cnt_q == '0));
        err_len_d   = err_len_q | (gf_o_en && ((gf_o_len == '0) || (gf_o_len > LEN_W'(MAX_LEN))));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gi_valid_q   <= 1'b0;
            gi_data_q    <= '0;
            gi_id_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_len_q   <= '0;
            cnt_q        <= '0;
            err_unexp_q  <= 1'b0;
            err_len_q    <= 1'b0;
        end else begin
            gi_valid_q   <= gi_valid_d;
            gi_data_q    <= gi_data_d;
            gi_id_q      <= gi_id_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_len_q   <= resp_len_d;
            cnt_q        <= cnt_d;
            err_unexp_q  <= err_unexp_d;
            err_len_q    <= err_len_d;
        end
    end

    // Arbitration pointer, per-requester sequence numbers and the issue-order FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                seq_q[i] <= '0;
            end
            for (int i = 0; i < OUTST; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                seq_q[win]       <= seq_q[win] + SEQ_W'(1);
                rr_q             <= win + IDX_W'(1);
                fifo_q[wr_ptr_q] <= win;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign gf_i_valid = gi_valid_q;
    assign gf_i_data  = gi_data_q;
    assign gf_t_id    = gi_id_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_len   = resp_len_q;
    assign outst_cnt  = cnt_q;
    assign err_unexp  = err_unexp_q;
    assign err_len    = err_len_q;

endmodule

// File: doc/gfifo_req_sched.md
Name: gfifo_req_sched

Overview:
- Shares the single 512-bit GFIFO host channel (iData/tId in, oData/oDataEn/oDataLen out) between NUM_REQ on-DUT requesters.
- Round-robin arbitrates requests and stamps each with a 22-bit transaction ID {requester index, per-requester sequence}.
- The return channel carries no ID, so the block tracks outstanding transactions in order and routes each response back to its originating requester.
- Sits in kme_tb_dut between the requester agents and the GFIFO bind signals.

Parameters:
- NUM_REQ, 4, number of requesters (power of 2, 2..8).
- DATA_W, 512, payload width, both directions.
- ID_W, 22, transaction ID width; IDX_W = log2(NUM_REQ), SEQ_W = ID_W - IDX_W.
- LEN_W, 4, response length field width (64-bit word units).
- MAX_LEN, 8, largest legal response length.
- OUTST, 8, maximum outstanding transactions (order FIFO depth, power of 2).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_data  in  NUM_REQ*DATA_W  request payloads; requester i occupies slice i.
- gf_i_data  out  DATA_W  to GFIFO iData.
- gf_t_id  out  ID_W  to GFIFO tId.
- gf_i_valid  out  1  GFIFO input beat valid.
- gf_i_ready  in  1  GFIFO accepts beat.
- gf_o_data  in  DATA_W  from GFIFO oData.
- gf_o_en  in  1  response beat strobe (oDataEn); no backpressure.
- gf_o_len  in  LEN_W  from GFIFO oDataLen.
- resp_valid  out  NUM_REQ  one-hot response strobe to requester.
- resp_data  out  DATA_W  response payload, shared by all requesters.
- resp_len  out  LEN_W  response length.
- outst_cnt  out  log2(OUTST)+1  outstanding transaction count.
- err_unexp  out  1  sticky: response arrived with nothing outstanding.
- err_len  out  1  sticky: response length was 0 or greater than MAX_LEN.

Behaviour:
- Reset: all outputs 0; RR pointer 0; all sequence counters 0; order FIFO empty; sticky errors cleared. Reset mid-transaction drops all outstanding state; responses after reset count as unexpected.
- Slot free: `slot_free = !gf_i_valid || gf_i_ready`.
- Grant condition: `slot_free && outst_cnt < OUTST`, computed from registered state.
- Grant selection: the first asserted req_valid at or after the RR pointer, searching upward with wrap.
- req_ready[w] = 1 for the winner w only, combinational.
- Accept (req_valid[w] && req_ready[w]) at cycle N:
  - At N+1: gf_i_valid=1, gf_i_data = req_data slice w, gf_t_id = {w, seq[w]}.
  - seq[w] increments and wraps at 2^SEQ_W.
  - RR pointer becomes w+1 mod NUM_REQ.
  - w is pushed to the order FIFO.
- gf_i_valid holds with stable data/ID until gf_i_ready; it drops the cycle after handshake unless a new accept occurs.
- Sustained throughput is 1 beat/clk.
- Response, gf_o_en at cycle M with order FIFO non-empty:
  - Pop the head h.
  - At M+1: resp_valid[h]=1 for one cycle, resp_data=gf_o_data, resp_len=gf_o_len.
  - resp_data and resp_len hold their last value while resp_valid=0.
- Response with order FIFO empty: the response is dropped, no resp_valid, err_unexp set.
- gf_o_len of 0 or greater than MAX_LEN: err_len set, but the response is still routed normally.
- Simultaneous accept and response in the same cycle: push and pop both occur, outst_cnt is unchanged. Grant still uses the pre-pop count, so there is no bypass when full.
- outst_cnt = pushes - pops, registered. It never exceeds OUTST and never underflows.

Test Plan:
- Reset, then req_valid=4'b0001 with data A, gf_i_ready=1 -> req_ready[0] same cycle; next cycle gf_i_valid=1, gf_i_data=A, gf_t_id=22'h000000; outst_cnt=1.
- All four requesters held valid, gf_i_ready=1 -> grants in order 0,1,2,3,0,...; IDs 0x000000, 0x100000, 0x200000, 0x300000, then 0x000001.
- gf_i_ready=0 for 5 cycles with requests pending -> gf_i_valid/data/ID stable and req_ready=0; one beat completes on release.
- 8 accepts with no responses -> 9th request is not granted (req_ready=0, outst_cnt=8); a gf_o_en pulse frees a slot and the next cycle grants.
- Issue from requesters 2,0,3, then three gf_o_en pulses with lens 1,8,4 -> resp_valid one-hot 0100, 0001, 1000 with matching data/len, each one cycle after its strobe.
- gf_o_en with nothing outstanding -> no resp_valid, err_unexp=1 and sticky. Then a response with gf_o_len=0 -> err_len=1 and the response is still routed. Then rst_n low mid-stream -> all outputs and errors clear.
